// File: rtl/pc_fetch_unit.sv
// Fetch PC register with BTB-based next-PC prediction, EX-driven mispredict
// recovery, halt tracking and a saturating mispredict counter.
module pc_fetch_unit #(
   parameter int unsigned     PC_W        = 16,
   parameter int unsigned     BTB_ENTRIES = 8,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int unsigned     CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             hlt_i,
   output logic [PC_W-1:0]  pc_o,
   output logic             pred_taken_o,
   output logic [PC_W-1:0]  pred_next_o,
   input  logic             res_valid_i,
   input  logic             res_is_branch_i,
   input  logic [PC_W-1:0]  res_pc_i,
   input  logic             res_taken_i,
   input  logic [PC_W-1:0]  res_target_i,
   input  logic [PC_W-1:0]  res_pred_next_i,
   output logic             flush_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] mispredict_cnt_o
);

   localparam int unsigned     IDX     = $clog2(BTB_ENTRIES);
   localparam int unsigned     TAG_W   = PC_W - IDX - 1;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

   typedef enum logic {RUN, HALTED} state_t;

   state_t           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [CNT_W-1:0] cnt_q;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
   logic [PC_W-1:0]        btb_target [BTB_ENTRIES];
   logic [1:0]             btb_ctr    [BTB_ENTRIES];

   logic [IDX-1:0]   f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX-1:0]   r_idx;
   logic [TAG_W-1:0] r_tag;
   logic             r_hit;
   logic [PC_W-1:0]  actual_next;
   logic             mispredict;

   // Fetch-side lookup reads the BTB as it stood before this edge's update.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here via
      // unconditional assignments) so no latch is inferred.
      f_idx        = pc_q[IDX:1];
      f_tag        = pc_q[PC_W-1:IDX+1];
      f_hit        = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      pred_taken_o = f_hit && btb_ctr[f_idx][1] && (state_q == RUN);
      pred_next_o  = pred_taken_o ? btb_target[f_idx] : pc_q + PC_STEP;
   end

   always_comb begin
      r_idx       = res_pc_i[IDX:1];
      r_tag       = res_pc_i[PC_W-1:IDX+1];
      r_hit       = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
      actual_next = (res_is_branch_i && res_taken_i) ? res_target_i
                                                     : res_pc_i + PC_STEP;
      mispredict  = res_valid_i && (actual_next != res_pred_next_i);
   end

   assign flush_o          = mispredict && !rst;
   assign pc_o             = pc_q;
   assign halted_o         = (state_q == HALTED);
   assign mispredict_cnt_o = cnt_q;

   // PC / halt FSM: a mispredict beats both HALTED and stall.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         if (mispredict) begin
            pc_q    <= actual_next;
            state_q <= RUN;
         end else if (state_q == HALTED || stall_i) begin
            pc_q <= pc_q;
         end else if (hlt_i) begin
            state_q <= HALTED;
         end else begin
            pc_q <= pred_next_o;
         end
         if (mispredict && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the BTB array is reset explicitly; valid bits and counters must
      // start known, and tags/targets are cleared too so lookups never see X.
      if (rst) begin
         btb_valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (res_valid_i) begin
         if (res_is_branch_i) begin
            if (r_hit) begin
               if (res_taken_i) begin
                  if (btb_ctr[r_idx] != 2'b11) btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
                  btb_target[r_idx] <= res_target_i;
               end else if (btb_ctr[r_idx] != 2'b00) begin
                  btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
               end
            end else if (res_taken_i) begin
               btb_valid[r_idx]  <= 1'b1;
               btb_tag[r_idx]    <= r_tag;
               btb_target[r_idx] <= res_target_i;
               btb_ctr[r_idx]    <= 2'b10;
            end
         end else if (r_hit) begin
            // Non-branch aliasing onto a live entry: drop the false prediction.
            btb_valid[r_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic for pc_fetch_unit, checked every
// cycle against an array-based reference model of the predictor.
module tb_pc_fetch_unit;

   localparam int N   = 8;
   localparam int IDX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, hlt_i;
   logic [15:0] pc_o, pred_next_o;
   logic        pred_taken_o;
   logic        res_valid_i, res_is_branch_i, res_taken_i;
   logic [15:0] res_pc_i, res_target_i, res_pred_next_i;
   logic        flush_o, halted_o;
   logic [15:0] mispredict_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [15:0] m_pc;
   bit          m_halted;
   int          m_cnt;
   bit          m_valid [N];
   int          m_tag   [N];
   logic [15:0] m_tgt   [N];
   int          m_ctr   [N];

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .hlt_i(hlt_i),
      .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_next_o(pred_next_o),
      .res_valid_i(res_valid_i), .res_is_branch_i(res_is_branch_i),
      .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
      .res_target_i(res_target_i), .res_pred_next_i(res_pred_next_i),
      .flush_o(flush_o), .halted_o(halted_o),
      .mispredict_cnt_o(mispredict_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_halted = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 16'h0; m_ctr[i] = 1;
      end
   endtask

   function automatic int idx_of(input logic [15:0] pc);
      return (int'(pc) / 2) % N;
   endfunction

   function automatic int tag_of(input logic [15:0] pc);
      return int'(pc) >> (IDX + 1);
   endfunction

   // Prediction for an arbitrary PC from the model's BTB, ignoring halt.
   function automatic logic [15:0] model_guess(input logic [15:0] pc, output bit taken);
      int i;
      i = idx_of(pc);
      taken = m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
      return taken ? m_tgt[i] : 16'(pc + 16'd2);
   endfunction

   task automatic clear_inputs();
      stall_i = 0; hlt_i = 0; res_valid_i = 0; res_is_branch_i = 0;
      res_pc_i = 0; res_taken_i = 0; res_target_i = 0; res_pred_next_i = 0;
   endtask

   // Called at a negedge with inputs driven: compare, clock, advance model.
   task automatic step();
      bit          pt, mis, rhit;
      logic [15:0] pn, actual;
      int          ri;
      #1;
      pn = model_guess(m_pc, pt);
      if (m_halted) begin
         pt = 0;
         pn = 16'(m_pc + 16'd2);
      end
      actual = (res_is_branch_i && res_taken_i) ? res_target_i : 16'(res_pc_i + 16'd2);
      mis    = res_valid_i && (actual != res_pred_next_i);
      check("pc", pc_o, m_pc);
      check("pred_taken", pred_taken_o, pt);
      check("pred_next", pred_next_o, pn);
      check("flush", flush_o, mis);
      check("halted", halted_o, m_halted);
      check("mp_cnt", mispredict_cnt_o, m_cnt);
      @(posedge clk);
      if (mis) begin
         m_pc = actual; m_halted = 0;
      end else if (!m_halted && !stall_i) begin
         if (hlt_i) m_halted = 1;
         else       m_pc = pn;
      end
      if (mis && m_cnt < 16'hFFFF) m_cnt++;
      if (res_valid_i) begin
         ri   = idx_of(res_pc_i);
         rhit = m_valid[ri] && m_tag[ri] == tag_of(res_pc_i);
         if (res_is_branch_i) begin
            if (rhit && res_taken_i) begin
               m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
               m_tgt[ri] = res_target_i;
            end else if (rhit) begin
               m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
            end else if (res_taken_i) begin
               m_valid[ri] = 1; m_tag[ri] = tag_of(res_pc_i);
               m_tgt[ri] = res_target_i; m_ctr[ri] = 2;
            end
         end else if (rhit) begin
            m_valid[ri] = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic resolve(input bit br, input logic [15:0] rpc, input bit tk,
                          input logic [15:0] tgt, input logic [15:0] rpn);
      res_valid_i = 1; res_is_branch_i = br; res_pc_i = rpc;
      res_taken_i = tk; res_target_i = tgt; res_pred_next_i = rpn;
   endtask

   // Steer fetch to an arbitrary PC via a mispredicted non-branch.
   task automatic redirect(input logic [15:0] target);
      clear_inputs();
      resolve(0, 16'(target - 16'd2), 0, 16'h0, ~target);
      step();
      clear_inputs();
   endtask

   task automatic mid_reset();
      #3 rst = 1;
      #1;
      check("rst_pc", pc_o, 16'h0000);
      check("rst_flush", flush_o, 0);
      check("rst_pred_taken", pred_taken_o, 0);
      check("rst_pred_next", pred_next_o, 16'h0002);
      check("rst_halted", halted_o, 0);
      check("rst_cnt", mispredict_cnt_o, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   logic [15:0] pool [5] = '{16'h0010, 16'h0020, 16'h0090, 16'h0110, 16'hFFFE};

   initial begin
      bit          g;
      logic [15:0] actual;
      int          r;
      clear_inputs();
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;

      // sequential fetch from reset
      for (int i = 0; i < 4; i++) begin
         #1 check("seq_pc", pc_o, 16'(2 * i));
         check("seq_flush", flush_o, 0);
         step();
      end

      // cold taken branch allocates and redirects
      resolve(1, 16'h0010, 1, 16'h0040, 16'h0012);
      #1 check("cold_flush", flush_o, 1);
      step();
      clear_inputs();
      #1 check("cold_pc", pc_o, 16'h0040);
      check("cold_cnt", mispredict_cnt_o, 1);
      redirect(16'h0010);
      #1 check("hit_pt", pred_taken_o, 1);
      check("hit_pn", pred_next_o, 16'h0040);

      // hysteresis: 10 -> 01 -> 10 -> 11 -> 10
      resolve(1, 16'h0010, 0, 16'h0040, 16'h0012); step(); clear_inputs();
      redirect(16'h0010);
      #1 check("hyst_nt_pt", pred_taken_o, 0);
      check("hyst_nt_pn", pred_next_o, 16'h0012);
      repeat (2) begin
         resolve(1, 16'h0010, 1, 16'h0040, 16'h0040); step(); clear_inputs();
      end
      resolve(1, 16'h0010, 0, 16'h0040, 16'h0012); step(); clear_inputs();
      redirect(16'h0010);
      #1 check("hyst_sat_pt", pred_taken_o, 1);

      // flush beats stall and halt
      stall_i = 1; hlt_i = 1;
      resolve(1, 16'h0050, 1, 16'h0100, 16'h0000);
      step(); clear_inputs();
      #1 check("fsh_pc", pc_o, 16'h0100);
      check("fsh_halted", halted_o, 0);

      // halt, hold, wrong-path recovery
      redirect(16'h0020);
      hlt_i = 1; step(); hlt_i = 0;
      for (int i = 0; i < 6; i++) begin
         #1 check("hlt_pc", pc_o, 16'h0020);
         check("hlt_state", halted_o, 1);
         step();
      end
      redirect(16'h0030);
      #1 check("unhlt_state", halted_o, 0);
      check("unhlt_pc", pc_o, 16'h0030);

      // wrap and alias invalidation
      redirect(16'hFFFE);
      step();
      #1 check("wrap_pc", pc_o, 16'h0000);
      resolve(0, 16'h0010, 0, 16'h0000, 16'h0040);
      #1 check("alias_flush", flush_o, 1);
      step(); clear_inputs();
      redirect(16'h0010);
      #1 check("alias_inval", pred_taken_o, 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c == 1000 || c == 2000) mid_reset();
         clear_inputs();
         stall_i = ($urandom_range(0, 4) == 0);
         hlt_i   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 1) == 1) begin
            res_valid_i     = 1;
            res_is_branch_i = ($urandom_range(0, 3) != 0);
            r               = $urandom_range(0, 5);
            res_pc_i        = (r < 5) ? pool[r] : 16'($urandom & 32'hFFFE);
            res_taken_i     = $urandom_range(0, 1);
            r               = $urandom_range(0, 5);
            res_target_i    = (r < 5) ? pool[r] : 16'($urandom & 32'hFFFE);
            actual = (res_is_branch_i && res_taken_i) ? res_target_i : 16'(res_pc_i + 16'd2);
            case ($urandom_range(0, 3))
               0, 1:    res_pred_next_i = actual;
               2:       res_pred_next_i = model_guess(res_pc_i, g);
               default: res_pred_next_i = 16'($urandom & 32'hFFFE);
            endcase
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-cycle PC register and PC control path, for the 5-stage pipeline.
- Holds the fetch PC and predicts the next PC with a direct-mapped branch target buffer (BTB) using 2-bit saturating counters.
- Takes branch resolution from EX and redirects and flushes on mispredict.
- Tracks halt state and counts mispredicts.

Parameters:
- PC_W, 16, PC width in bits.
- BTB_ENTRIES, 8, number of BTB entries; power of 2, minimum 2.
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the fetch PC (IF/ID stall from the hazard unit).
- hlt_i  in  1  the instruction fetched at pc_o is HLT (opcode 4'b1111).
- pc_o  out  PC_W  current fetch PC, to instruction memory.
- pred_taken_o  out  1  BTB predicts taken for pc_o.
- pred_next_o  out  PC_W  predicted next PC; the pipeline carries it down to EX.
- res_valid_i  in  1  EX presents a resolved instruction this cycle.
- res_is_branch_i  in  1  the resolved instruction is B, BR or PCS-class control flow.
- res_pc_i  in  PC_W  PC of the resolved instruction.
- res_taken_i  in  1  actual branch outcome.
- res_target_i  in  PC_W  actual target when taken.
- res_pred_next_i  in  PC_W  pred_next_o value that was carried with this instruction.
- flush_o  out  1  mispredict; squash IF/ID and ID/EX this cycle.
- halted_o  out  1  unit is in HALTED state.
- mispredict_cnt_o  out  CNT_W  saturating mispredict count.

Behaviour:
- Reset (async):
  - pc_o = RESET_PC; state = RUN; mispredict_cnt_o = 0.
  - All BTB valid bits = 0; all counters = 2'b01.
  - Outputs during reset: flush_o = 0, pred_taken_o = 0, pred_next_o = RESET_PC + 2, halted_o = 0.
- Indexing:
  - IDX = log2(BTB_ENTRIES); index = pc[IDX:1] (bit 0 is ignored; instructions are 2-byte aligned).
  - tag = pc[PC_W-1:IDX+1].
- Lookup (combinational on pc_o):
  - hit = valid & tag match.
  - pred_taken_o = hit & counter[1] & (state == RUN).
  - pred_next_o = pred_taken_o ? entry target : pc_o + 2.
  - All PC arithmetic is modulo 2^PC_W; 0xFFFE + 2 wraps to 0x0000.
- Resolution (combinational, when res_valid_i):
  - actual_next = (res_is_branch_i & res_taken_i) ? res_target_i : res_pc_i + 2.
  - mispredict = res_valid_i & (actual_next != res_pred_next_i).
  - flush_o = mispredict, asserted in the same cycle.
- Next-PC priority, registered on the clock edge:
  1. mispredict: pc <= actual_next; state <= RUN. Overrides stall_i and HALTED.
  2. state == HALTED: pc holds.
  3. stall_i: pc holds; hlt_i is ignored.
  4. hlt_i: pc holds; state <= HALTED.
  5. Otherwise: pc <= pred_next_o.
- State machine: RUN, HALTED.
  - RUN -> HALTED on rule 4.
  - HALTED -> RUN only on mispredict (a wrong-path HLT) or rst.
  - halted_o = (state == HALTED).
- BTB update, on the clock edge, when res_valid_i:
  - Branch, hit, taken: counter saturates up at 2'b11; target <= res_target_i.
  - Branch, hit, not taken: counter saturates down at 2'b00.
  - Branch, miss, taken: allocate/replace entry: valid = 1, tag, target, counter = 2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch with a tag hit (aliased false prediction): valid <= 0.
  - A lookup and an update to the same index in the same cycle: the lookup sees the old contents.
- Counter: mispredict_cnt_o increments by 1 on each mispredict cycle and saturates at all-ones.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk.

Test Plan:
- Reset, then 3 cycles with no resolution -> pc_o sequence 0x0000, 0x0002, 0x0004, 0x0006; pred_taken_o = 0; flush_o = 0.
- Cold taken branch: res_valid_i = 1, res_pc_i = 0x0010, res_taken_i = 1, res_target_i = 0x0040, res_pred_next_i = 0x0012 -> flush_o = 1 that cycle; next pc_o = 0x0040; mispredict_cnt_o = 1. On the next fetch of 0x0010, pred_taken_o = 1 and pred_next_o = 0x0040.
- Hysteresis: after the allocation above (counter 2'b10), one not-taken resolution -> counter 2'b01, so the next fetch of 0x0010 predicts not-taken with pred_next_o = 0x0012. Two taken resolutions then saturate the counter at 2'b11, and a single not-taken still predicts taken.
- Flush over stall and halt: assert stall_i and hlt_i together with a mispredict to 0x0100 -> pc_o = 0x0100 next cycle; halted_o = 0.
- Halt: hlt_i = 1 at pc 0x0020 with no stall -> halted_o = 1 and pc_o held at 0x0020 for 5+ cycles. A later mispredict to 0x0030 -> halted_o = 0 and pc_o = 0x0030.
- Wrap and alias: PC_W = 16, pc 0xFFFE with no hit -> next pc_o = 0x0000. A non-branch resolution at a PC whose tag hits -> flush_o = 1 and the entry becomes invalid.
